conv_layer_scheduler: RTL and testbench

CONV_LAYER_SCHEDULER -- requirements
Module: conv_layer_scheduler

---
 rtl/conv_layer_scheduler.sv | 147 ++++++++++++++
 tb/tb_conv_layer_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_scheduler.sv
// Convolution layer scheduler: for each output channel, load the kernel
// weights, start the window controller, count window writes into the
// feature map, then advance to the next channel.
// Optional feature: define SCHED_PERF_CNT_EN to build the busy-cycle counter
// on o_cycle_cnt; otherwise o_cycle_cnt is tied to zero.
module conv_layer_scheduler #(
    parameter int NUM_CH     = 6,
    parameter int WIN_PER_CH = 784,
    parameter int WT_PER_CH  = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_layer_start,
    input  logic        i_abort,
    output logic        o_busy,
    output logic        o_layer_done,
    output logic        o_wt_rd_en,
    output logic [7:0]  o_wt_addr,
    output logic        o_ctrl_start,
    input  logic        i_ctrl_done,
    input  logic        i_win_fire,
    output logic [2:0]  o_ch_idx,
    output logic        o_fm_wr_en,
    output logic [12:0] o_fm_wr_addr,
    output logic        o_err,
    output logic [31:0] o_cycle_cnt
);

    localparam int WIN_W = $clog2(WIN_PER_CH + 1);
    localparam int K_W   = (WT_PER_CH > 1) ? $clog2(WT_PER_CH) : 1;

    typedef enum logic [2:0] {IDLE, LOAD_W, START, RUN, NEXT, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [K_W-1:0]   wt_k;
    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] final_cnt;
    logic [2:0]       ch_idx;
    logic             err;
    logic             win_room;
    logic             fire_write;
    logic             last_k;
    logic             accepted;
    logic             err_event;

    assign win_room   = (win_cnt < WIN_W'(WIN_PER_CH));
    assign fire_write = (state == RUN) && i_win_fire && win_room;
    // Count as it will stand after this cycle, so a fire coincident with
    // ctrl_done is credited before the pass length is judged.
    assign final_cnt  = win_cnt + WIN_W'(fire_write);
    assign last_k     = (wt_k == K_W'(WT_PER_CH - 1));
    assign accepted   = (state == IDLE) && i_layer_start && !i_abort;
    assign err_event  = ((state == RUN) && i_win_fire && !win_room)
                      || ((state == RUN) && i_ctrl_done && (final_cnt != WIN_W'(WIN_PER_CH)))
                      || ((state != RUN) && (i_win_fire || i_ctrl_done));

    assign o_ch_idx = ch_idx;
    assign o_err    = err;

    // State register; reset returns to IDLE without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic and state-decoded strobes; abort overrides every transition.
    always_comb begin
        state_next   = state;
        o_busy       = (state != IDLE);
        o_wt_rd_en   = 1'b0;
        o_wt_addr    = 8'd0;
        o_ctrl_start = 1'b0;
        o_fm_wr_en   = 1'b0;
        o_fm_wr_addr = 13'd0;
        o_layer_done = 1'b0;
        case (state)
            IDLE: begin
                if (i_layer_start) state_next = LOAD_W;
            end
            LOAD_W: begin
                o_wt_rd_en = 1'b1;
                o_wt_addr  = 8'(int'(ch_idx) * WT_PER_CH + int'(wt_k));
                if (last_k) state_next = START;
            end
            START: begin
                o_ctrl_start = 1'b1;
                state_next   = RUN;
            end
            RUN: begin
                if (fire_write) begin
                    o_fm_wr_en   = 1'b1;
                    o_fm_wr_addr = 13'(int'(ch_idx) * WIN_PER_CH + int'(win_cnt));
                end
                if (i_ctrl_done)
                    state_next = (ch_idx == 3'(NUM_CH - 1)) ? DONE : NEXT;
            end
            NEXT: begin
                state_next = LOAD_W;
            end
            DONE: begin
                o_layer_done = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (i_abort) state_next = IDLE;
    end

    // Channel, tap and window counters plus the sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wt_k    <= '0;
            win_cnt <= '0;
            ch_idx  <= 3'd0;
            err     <= 1'b0;
        end else begin
            // Tap index only runs inside LOAD_W, so any exit (including abort) rewinds it.
            wt_k <= ((state == LOAD_W) && !last_k) ? wt_k + K_W'(1) : '0;

            if (accepted || (state == START)) win_cnt <= '0;
            else if (fire_write)              win_cnt <= win_cnt + WIN_W'(1);

            if (accepted)                            ch_idx <= 3'd0;
            else if ((state == NEXT) && !i_abort)    ch_idx <= ch_idx + 3'd1;

            if (accepted)       err <= 1'b0;
            else if (err_event) err <= 1'b1;
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] cycle_cnt;

    // Busy-cycle counter: restarts on an accepted layer start, holds while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         cycle_cnt <= 32'd0;
        else if (accepted) cycle_cnt <= 32'd0;
        else if (o_busy)   cycle_cnt <= cycle_cnt + 32'd1;
    end

    assign o_cycle_cnt = cycle_cnt;
`else
    assign o_cycle_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Scoreboard bench for conv_layer_scheduler: stimulus pushes expected weight
// and feature-map addresses; a negedge monitor pops and compares them.
module tb_conv_layer_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_layer_start;
    logic        i_abort;
    logic        o_busy;
    logic        o_layer_done;
    logic        o_wt_rd_en;
    logic [7:0]  o_wt_addr;
    logic        o_ctrl_start;
    logic        i_ctrl_done;
    logic        i_win_fire;
    logic [2:0]  o_ch_idx;
    logic        o_fm_wr_en;
    logic [12:0] o_fm_wr_addr;
    logic        o_err;
    logic [31:0] o_cycle_cnt;

    int checks   = 0;
    int failures = 0;
    int wt_q[$];
    int fm_q[$];
    int ctrl_start_cnt = 0;
    int layer_done_cnt = 0;
    int wt_read_cnt    = 0;
    int fm_write_cnt   = 0;

    conv_layer_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .i_layer_start(i_layer_start),
        .i_abort      (i_abort),
        .o_busy       (o_busy),
        .o_layer_done (o_layer_done),
        .o_wt_rd_en   (o_wt_rd_en),
        .o_wt_addr    (o_wt_addr),
        .o_ctrl_start (o_ctrl_start),
        .i_ctrl_done  (i_ctrl_done),
        .i_win_fire   (i_win_fire),
        .o_ch_idx     (o_ch_idx),
        .o_fm_wr_en   (o_fm_wr_en),
        .o_fm_wr_addr (o_fm_wr_addr),
        .o_err        (o_err),
        .o_cycle_cnt  (o_cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: compare every strobe against the scoreboard queues.
    initial begin
        forever begin
            @(negedge clk);
            if (o_wt_rd_en) begin
                wt_read_cnt++;
                if (wt_q.size() == 0) check("unexpected_wt_read", 32'(o_wt_addr), 32'hFFFF_FFFF);
                else check("wt_addr", 32'(o_wt_addr), 32'(wt_q.pop_front()));
            end else begin
                check("wt_addr_idle_zero", 32'(o_wt_addr), 32'd0);
            end
            if (o_fm_wr_en) begin
                fm_write_cnt++;
                if (fm_q.size() == 0) check("unexpected_fm_write", 32'(o_fm_wr_addr), 32'hFFFF_FFFF);
                else check("fm_addr", 32'(o_fm_wr_addr), 32'(fm_q.pop_front()));
            end else begin
                check("fm_addr_idle_zero", 32'(o_fm_wr_addr), 32'd0);
            end
            if (o_ctrl_start) ctrl_start_cnt++;
            if (o_layer_done) layer_done_cnt++;
        end
    end

    // Global time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push_wt(input int ch, input int n);
        for (int k = 0; k < n; k++) wt_q.push_back(ch * 26 + k);
    endtask

    task automatic start_layer();
        @(posedge clk); #1 i_layer_start = 1'b1;
        @(posedge clk); #1 i_layer_start = 1'b0;
    endtask

    task automatic wait_ctrl_start(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 80; t++) begin
            @(negedge clk);
            if (o_ctrl_start) begin
                ok = 1'b1;
                break;
            end
        end
        check("ctrl_start_seen", 32'(ok), 32'd1);
    endtask

    // mode 0: ctrl_done one cycle after the last fire; 1: coincident; 2: no ctrl_done.
    task automatic run_channel(input int ch, input int nfires, input int mode);
        bit ok;
        push_wt(ch, 26);
        wait_ctrl_start(ok);
        if (!ok) return;
        @(posedge clk); #1;
        for (int i = 0; i < nfires; i++) begin
            i_win_fire  = 1'b1;
            i_ctrl_done = (mode == 1) && (i == nfires - 1);
            if (i < 784) fm_q.push_back(ch * 784 + i);
            @(posedge clk); #1;
        end
        i_win_fire  = 1'b0;
        i_ctrl_done = 1'b0;
        if (mode == 0) begin
            i_ctrl_done = 1'b1;
            @(posedge clk); #1 i_ctrl_done = 1'b0;
        end
    endtask

    task automatic abort_one();
        i_abort = 1'b1;
        @(posedge clk); #1 i_abort = 1'b0;
    endtask

    initial begin
        int ld_snap;
        bit ok;
        reset = 1'b1;
        i_layer_start = 1'b0;
        i_abort = 1'b0;
        i_ctrl_done = 1'b0;
        i_win_fire = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_ch_idx", 32'(o_ch_idx), 32'd0);
        check("rst_ctrl_start", 32'(o_ctrl_start), 32'd0);
        check("rst_layer_done", 32'(o_layer_done), 32'd0);
        check("rst_cycle_cnt", o_cycle_cnt, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Full layer: even channels end one cycle after the last fire, odd ones coincident.
        start_layer();
        for (int ch = 0; ch < 6; ch++) run_channel(ch, 784, ch % 2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("full_ctrl_starts", 32'(ctrl_start_cnt), 32'd6);
        check("full_layer_done", 32'(layer_done_cnt), 32'd1);
        check("full_wt_reads", 32'(wt_read_cnt), 32'd156);
        check("full_fm_writes", 32'(fm_write_cnt), 32'd4704);
        check("full_err", 32'(o_err), 32'd0);
        check("full_busy", 32'(o_busy), 32'd0);
        check("full_ch_idx_hold", 32'(o_ch_idx), 32'd5);
`ifdef SCHED_PERF_CNT_EN
        check("full_cycle_cnt", o_cycle_cnt, 32'd4875);
`else
        check("full_cycle_cnt_tied", o_cycle_cnt, 32'd0);
`endif

        // Short pass on ch0 flags an error; ch1 still starts at address 784.
        start_layer();
        run_channel(0, 700, 0);
        check("short_pass_err", 32'(o_err), 32'd1);
        run_channel(1, 784, 1);
        check("err_sticky", 32'(o_err), 32'd1);
        ld_snap = layer_done_cnt;
        abort_one();
        @(negedge clk);
        check("abort_next_busy", 32'(o_busy), 32'd0);
        check("abort_next_ch_idx", 32'(o_ch_idx), 32'd1);
        check("abort_next_err", 32'(o_err), 32'd1);

        // Fire during LOAD_W, then abort mid-LOAD_W after ten weight reads.
        push_wt(0, 10);
        start_layer();
        @(negedge clk);
        check("start_clears_err", 32'(o_err), 32'd0);
        repeat (3) @(posedge clk);
        #1 i_win_fire = 1'b1;
        @(posedge clk); #1 i_win_fire = 1'b0;
        @(negedge clk);
        check("loadw_fire_err", 32'(o_err), 32'd1);
        repeat (5) @(posedge clk);
        #1 abort_one();
        @(negedge clk);
        check("abort_loadw_busy", 32'(o_busy), 32'd0);
        check("abort_loadw_err", 32'(o_err), 32'd1);
        check("abort_no_layer_done", 32'(layer_done_cnt), 32'(ld_snap));
        check("abort_loadw_reads", 32'(wt_q.size()), 32'd0);

        // 785th fire is dropped and flagged.
        start_layer();
        run_channel(0, 785, 0);
        check("overrun_err", 32'(o_err), 32'd1);
        abort_one();

        // Asynchronous reset in the middle of channel 3.
        start_layer();
        for (int ch = 0; ch < 3; ch++) run_channel(ch, 784, 1);
        run_channel(3, 100, 2);
        check("mid_run_ch_idx", 32'(o_ch_idx), 32'd3);
        i_win_fire = 1'b1;
        #1 reset = 1'b1;
        #1;
        check("async_rst_busy", 32'(o_busy), 32'd0);
        check("async_rst_fm_wr_en", 32'(o_fm_wr_en), 32'd0);
        check("async_rst_ch_idx", 32'(o_ch_idx), 32'd0);
        check("async_rst_cycle_cnt", o_cycle_cnt, 32'd0);
        @(posedge clk); #1 i_win_fire = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", 32'(o_busy), 32'd0);
        push_wt(0, 26);
        start_layer();
        wait_ctrl_start(ok);
        @(posedge clk); #1 abort_one();
        @(negedge clk);
        check("restart_reads_done", 32'(wt_q.size()), 32'd0);
        check("fm_queue_drained", 32'(fm_q.size()), 32'd0);
        check("restart_abort_busy", 32'(o_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
